// File: rtl/membus_master_pkg.sv
// Shared definitions for the PDP-6 memory-bus initiator: widths, FSM states
// and the address-to-bus field split.
package membus_master_pkg;

  localparam int WORD_W = 36;
  localparam int ADDR_W = 18;
  localparam int MA_W   = 15;
  localparam int SEL_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDWAIT,
    ST_RSP,
    ST_WDWAIT,
    ST_WRRS
  } state_t;

  // Address bits [21:35] (PDP numbering, bit 35 = LSB) go to the memory address lines.
  function automatic logic [MA_W-1:0] addr_ma(input logic [ADDR_W-1:0] a);
    return a[MA_W-1:0];
  endfunction

  // Address bits [18:21] select the memory module; bit 21 is shared with ma.
  function automatic logic [SEL_W-1:0] addr_sel(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-SEL_W];
  endfunction

endpackage

// File: rtl/membus_master_tmo.sv
// Saturating timeout counter: cleared by clr, counts while en, and flags
// expired on the clock that would bring the count to TMO_CYCLES.
module membus_master_tmo #(
  parameter int TMO_CYCLES = 1000,
  parameter int TMO_W      = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [TMO_W-1:0] ONE  = TMO_W'(1);

  logic [TMO_W-1:0] count_reg;

  // Count enabled clocks, holding at the last value instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LAST)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign expired = en && (count_reg == LAST);

endmodule

// File: rtl/membus_master.sv
// Processor-side membus initiator: turns valid/ready commands into read,
// write and read-pause-write bus cycles, with timeout on missing memory.
module membus_master
  import membus_master_pkg::*;
#(
  parameter int TMO_CYCLES = 1000,
  parameter int TMO_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic              cmd_wr,
  input  logic              cmd_fmc,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [WORD_W-1:0] wd_data,
  output logic              membus_rq_cyc,
  output logic              membus_rd_rq,
  output logic              membus_wr_rq,
  output logic [MA_W-1:0]   membus_ma,
  output logic [SEL_W-1:0]  membus_sel,
  output logic              membus_fmc_select,
  output logic [WORD_W-1:0] membus_mb_out,
  output logic              membus_wr_rs,
  input  logic              membus_addr_ack,
  input  logic              membus_rd_rs,
  input  logic [WORD_W-1:0] membus_mb_in
);

  state_t              state_reg, state_next;
  logic                rd_reg, wr_reg, fmc_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_W-1:0]   wdata_reg, mb_reg, rdata_reg;
  logic                err_reg, phase_reg;
  logic                tmo_expired;

  membus_master_tmo #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_W     (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_next != state_reg),
    .en     ((state_reg == ST_ADDR) || (state_reg == ST_RDWAIT)),
    .expired(tmo_expired)
  );

  // State register; reset lands in IDLE so every bus line drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state and bus/handshake outputs, all decoded from the current state.
  always_comb begin
    state_next        = state_reg;
    cmd_ready         = 1'b0;
    rsp_valid         = 1'b0;
    wd_ready          = 1'b0;
    membus_rq_cyc     = 1'b0;
    membus_rd_rq      = 1'b0;
    membus_wr_rq      = 1'b0;
    membus_ma         = '0;
    membus_sel        = '0;
    membus_fmc_select = 1'b0;
    membus_mb_out     = '0;
    membus_wr_rs      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = (cmd_rd || cmd_wr) ? ST_ADDR : ST_RSP;
      end
      ST_ADDR: begin
        membus_rq_cyc     = 1'b1;
        membus_rd_rq      = rd_reg;
        membus_wr_rq      = wr_reg;
        membus_ma         = addr_ma(addr_reg);
        membus_sel        = addr_sel(addr_reg);
        membus_fmc_select = fmc_reg;
        membus_mb_out     = (wr_reg && !rd_reg) ? wdata_reg : '0;
        // An acknowledge on the expiry clock still wins.
        if (membus_addr_ack) state_next = rd_reg ? ST_RDWAIT : ST_WRRS;
        else if (tmo_expired) state_next = ST_RSP;
      end
      ST_RDWAIT: begin
        if (membus_rd_rs || tmo_expired) state_next = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = (rd_reg && wr_reg && !err_reg) ? ST_WDWAIT : ST_IDLE;
      end
      ST_WDWAIT: begin
        wd_ready = 1'b1;
        if (wd_valid) state_next = ST_WRRS;
      end
      ST_WRRS: begin
        membus_mb_out = wdata_reg;
        membus_wr_rs  = phase_reg;
        // RPW already answered after its read half, so it goes straight home.
        if (phase_reg) state_next = rd_reg ? ST_IDLE : ST_RSP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, read-data accumulation and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      fmc_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      mb_reg    <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      phase_reg <= 1'b0;
    end else begin
      phase_reg <= (state_reg == ST_WRRS) && !phase_reg;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            rd_reg    <= cmd_rd;
            wr_reg    <= cmd_wr;
            fmc_reg   <= cmd_fmc;
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            mb_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= !(cmd_rd || cmd_wr);
          end
        end
        ST_ADDR: begin
          if (!membus_addr_ack && tmo_expired) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        ST_RDWAIT: begin
          // The bus is wire-OR and idles at 0, so OR-ing every clock catches the strobe.
          mb_reg <= mb_reg | membus_mb_in;
          if (membus_rd_rs) begin
            rdata_reg <= mb_reg | membus_mb_in;
            err_reg   <= 1'b0;
          end else if (tmo_expired) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        ST_WDWAIT: begin
          if (wd_valid) wdata_reg <= wd_data;
        end
        ST_WRRS: begin
          if (phase_reg && !rd_reg) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_membus_master.sv
// Directed bench for membus_master: table of single bus cycles plus
// hand-written RPW, timeout, stray-pulse and reset sequences.
module tb_membus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_rd, cmd_wr, cmd_fmc;
  logic        cmd_ready;
  logic [17:0] cmd_addr;
  logic [35:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [35:0] rsp_rdata;
  logic        wd_valid, wd_ready;
  logic [35:0] wd_data;
  logic        membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select, membus_wr_rs;
  logic [14:0] membus_ma;
  logic [3:0]  membus_sel;
  logic [35:0] membus_mb_out, membus_mb_in;
  logic        membus_addr_ack, membus_rd_rs;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  membus_master #(.TMO_CYCLES(16), .TMO_W(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .cmd_fmc(cmd_fmc), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq), .membus_wr_rq(membus_wr_rq),
    .membus_ma(membus_ma), .membus_sel(membus_sel), .membus_fmc_select(membus_fmc_select),
    .membus_mb_out(membus_mb_out), .membus_wr_rs(membus_wr_rs),
    .membus_addr_ack(membus_addr_ack), .membus_rd_rs(membus_rd_rs), .membus_mb_in(membus_mb_in)
  );

  typedef struct {
    string       name;
    logic        rd, wr, fmc;
    logic [17:0] addr;
    logic [35:0] wdata;
    int          ack_dly;
    logic [35:0] strobe;     // mb_in on the clock before rd_rs
    logic [35:0] rs_data;    // mb_in on the rd_rs clock
    logic [14:0] exp_ma;
    logic [3:0]  exp_sel;
    logic [35:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end else begin
      $display("ok   %s: %0o", name, act);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    check({v.name, "/cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rd = v.rd; cmd_wr = v.wr; cmd_fmc = v.fmc;
    cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!v.rd && !v.wr) begin
      check({v.name, "/no_rq_cyc"}, membus_rq_cyc, 0);
      check({v.name, "/no_rq"}, {membus_rd_rq, membus_wr_rq, membus_wr_rs}, 0);
    end else begin
      check({v.name, "/rq_cyc"}, membus_rq_cyc, 1);
      check({v.name, "/rd_rq"}, membus_rd_rq, v.rd);
      check({v.name, "/wr_rq"}, membus_wr_rq, v.wr);
      check({v.name, "/ma"}, membus_ma, v.exp_ma);
      check({v.name, "/sel"}, membus_sel, v.exp_sel);
      check({v.name, "/fmc"}, membus_fmc_select, v.fmc);
      check({v.name, "/cmd_ready_busy"}, cmd_ready, 0);
      for (int i = 0; i < v.ack_dly; i++) begin
        check({v.name, "/mb_out_addr"}, membus_mb_out, v.rd ? 36'o0 : v.wdata);
        @(negedge clk);
      end
      check({v.name, "/rq_cyc_at_ack"}, membus_rq_cyc, 1);
      membus_addr_ack = 1'b1;
      @(negedge clk);
      membus_addr_ack = 1'b0;
      check({v.name, "/rq_cyc_dropped"}, membus_rq_cyc, 0);
      if (v.rd) begin
        membus_mb_in = v.strobe;
        @(negedge clk);
        membus_mb_in = v.rs_data;
        membus_rd_rs = 1'b1;
        @(negedge clk);
        membus_mb_in = '0;
        membus_rd_rs = 1'b0;
      end else begin
        check({v.name, "/wrrs0_mb_out"}, membus_mb_out, v.wdata);
        check({v.name, "/wrrs0_wr_rs"}, membus_wr_rs, 0);
        @(negedge clk);
        check({v.name, "/wrrs1_mb_out"}, membus_mb_out, v.wdata);
        check({v.name, "/wrrs1_wr_rs"}, membus_wr_rs, 1);
        @(negedge clk);
        check({v.name, "/post_wr_rs"}, membus_wr_rs, 0);
        check({v.name, "/post_mb_out"}, membus_mb_out, 0);
      end
    end
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({v.name, "/rsp_valid"}, rsp_valid, 1);
    check({v.name, "/rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({v.name, "/rsp_err"}, rsp_err, v.exp_err);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, "/rsp_done"}, rsp_valid, 0);
    check({v.name, "/back_idle"}, cmd_ready, 1);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [17:0] addr, input logic [35:0] wdata);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_wr = wr; cmd_fmc = 1'b0;
    cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{"rd_001000", 1'b1, 1'b0, 1'b0, 18'o001000, 36'o0, 4,
                36'o123456654321, 36'o0, 15'o01000, 4'h0, 36'o123456654321, 1'b0};
    vecs[1] = '{"wr_777777", 1'b0, 1'b1, 1'b0, 18'o777777, 36'o000000000017, 2,
                36'o0, 36'o0, 15'o77777, 4'hF, 36'o0, 1'b0};
    vecs[2] = '{"rd_fmc_740017", 1'b1, 1'b0, 1'b1, 18'o740017, 36'o0, 0,
                36'o400000000000, 36'o000000000001, 15'o40017, 4'hF, 36'o400000000001, 1'b0};
    vecs[3] = '{"empty_cmd", 1'b0, 1'b0, 1'b0, 18'o001234, 36'o0, 0,
                36'o0, 36'o0, 15'o0, 4'h0, 36'o0, 1'b1};
    vecs[4] = '{"wr_fmc_040000", 1'b0, 1'b1, 1'b1, 18'o040000, 36'o525252525252, 1,
                36'o0, 36'o0, 15'o40000, 4'h1, 36'o0, 1'b0};

    reset = 1'b1;
    cmd_valid = 0; cmd_rd = 0; cmd_wr = 0; cmd_fmc = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; wd_valid = 0; wd_data = '0;
    membus_addr_ack = 0; membus_rd_rs = 0; membus_mb_in = '0;
    repeat (3) @(negedge clk);
    check("reset/cmd_ready", cmd_ready, 1);
    check("reset/outputs", {rsp_valid, rsp_err, wd_ready, membus_rq_cyc, membus_rd_rq,
                            membus_wr_rq, membus_fmc_select, membus_wr_rs}, 0);
    check("reset/buses", {membus_ma, membus_sel, membus_mb_out, rsp_rdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Stray acknowledge and restart while idle must not start anything.
    membus_addr_ack = 1'b1; membus_rd_rs = 1'b1;
    @(negedge clk);
    membus_addr_ack = 1'b0; membus_rd_rs = 1'b0;
    @(negedge clk);
    check("stray/idle", {cmd_ready, membus_rq_cyc, rsp_valid}, 3'b100);

    // Read-pause-write: one response after the read, then the write half.
    issue(1'b1, 1'b1, 18'o000100, 36'o777);
    check("rpw/rq", {membus_rq_cyc, membus_rd_rq, membus_wr_rq}, 3'b111);
    check("rpw/mb_out_addr", membus_mb_out, 0);
    check("rpw/ma", membus_ma, 15'o00100);
    membus_addr_ack = 1'b1;
    @(negedge clk);
    membus_addr_ack = 1'b0;
    membus_mb_in = 36'o5;
    @(negedge clk);
    membus_mb_in = '0; membus_rd_rs = 1'b1;
    @(negedge clk);
    membus_rd_rs = 1'b0;
    check("rpw/rsp_valid", rsp_valid, 1);
    check("rpw/rsp_rdata", rsp_rdata, 36'o5);
    check("rpw/rsp_err", rsp_err, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rpw/rsp_held", {rsp_valid, wd_ready}, 2'b10);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rpw/wdwait", {wd_ready, rsp_valid, cmd_ready, membus_wr_rs}, 4'b1000);
      @(negedge clk);
    end
    wd_valid = 1'b1; wd_data = 36'o6;
    @(negedge clk);
    wd_valid = 1'b0; wd_data = '0;
    check("rpw/wrrs0", {membus_wr_rs, wd_ready, rsp_valid}, 3'b000);
    check("rpw/wrrs0_mb_out", membus_mb_out, 36'o6);
    @(negedge clk);
    check("rpw/wrrs1_wr_rs", membus_wr_rs, 1);
    check("rpw/wrrs1_mb_out", membus_mb_out, 36'o6);
    @(negedge clk);
    check("rpw/idle", {cmd_ready, rsp_valid, membus_wr_rs}, 3'b100);
    check("rpw/mb_out_cleared", membus_mb_out, 0);

    // Address phase timeout: rq_cyc must stay up for exactly 16 clocks.
    issue(1'b1, 1'b0, 18'o0, 36'o0);
    n = 0;
    while (membus_rq_cyc && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_addr/rq_cyc_clocks", n, 16);
    check("tmo_addr/rsp_valid", rsp_valid, 1);
    check("tmo_addr/rsp_err", rsp_err, 1);
    check("tmo_addr/rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Read-wait timeout: strobed data must be discarded on error.
    issue(1'b1, 1'b0, 18'o000200, 36'o0);
    membus_addr_ack = 1'b1;
    @(negedge clk);
    membus_addr_ack = 1'b0; membus_mb_in = 36'o7;
    @(negedge clk);
    membus_mb_in = '0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_rdwait/clocks", n, 16);
    check("tmo_rdwait/rsp_err", rsp_err, 1);
    check("tmo_rdwait/rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Next command after timeouts is handled normally.
    run_vec(vecs[0]);

    // Reset during the address phase drops rq_cyc without a clock edge.
    issue(1'b0, 1'b1, 18'o000300, 36'o1234);
    check("rst_addr/before", membus_rq_cyc, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_addr/bus", {membus_rq_cyc, membus_wr_rq}, 0);
    check("rst_addr/mb_out", membus_mb_out, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during read-wait.
    issue(1'b1, 1'b0, 18'o000400, 36'o0);
    membus_addr_ack = 1'b1;
    @(negedge clk);
    membus_addr_ack = 1'b0; membus_mb_in = 36'o11;
    #2 reset = 1'b1;
    #1;
    check("rst_rdwait/lines", {membus_rq_cyc, membus_wr_rs, rsp_valid}, 0);
    check("rst_rdwait/mb_out", membus_mb_out, 0);
    @(negedge clk);
    reset = 1'b0; membus_mb_in = '0;
    @(negedge clk);
    check("rst_rdwait/cmd_ready", cmd_ready, 1);
    check("rst_rdwait/rsp_rdata", rsp_rdata, 0);

    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
